// File: rtl/ntt_mdc_reorder_if.sv
// Two-lane coefficient stream between the MDC NTT pipeline and its reorder buffer.
// master drives the bit-reversed input pairs; slave returns natural-order pairs and the error flag.
interface ntt_mdc_reorder_if #(
    parameter int LOGQ = 2
);
    logic            in_start;
    logic [LOGQ-1:0] in_0;
    logic [LOGQ-1:0] in_1;
    logic            out_start;
    logic            out_valid;
    logic [LOGQ-1:0] out_0;
    logic [LOGQ-1:0] out_1;
    logic            err;

    modport master (
        output in_start, in_0, in_1,
        input  out_start, out_valid, out_0, out_1, err
    );

    modport slave (
        input  in_start, in_0, in_1,
        output out_start, out_valid, out_0, out_1, err
    );
endinterface

// File: rtl/ntt_mdc_reorder.sv
// Ping-pong reorder buffer: bit-reversed NTT output pairs in, natural-order pairs out.
// Define NTT_REORDER_ERR_EN to build the sticky in_start protocol-violation detector on err.
module ntt_mdc_reorder #(
    parameter int LOGQ       = 0,
    parameter int LOGN       = 0,
    parameter int DELAY_BRAM = 0
) (
    input logic               clk,
    input logic               rst,
    ntt_mdc_reorder_if.slave  bus
);
    localparam int QW = (LOGQ < 2) ? 2 : LOGQ;
    localparam int AW = ((LOGN < 2) ? 2 : LOGN) - 1;
    localparam int N2 = 1 << AW;
    localparam int DB = (DELAY_BRAM < 1) ? 1 : DELAY_BRAM;
    localparam logic [AW-1:0] LAST = AW'(N2 - 1);

    typedef enum logic {W_IDLE, W_WRITE} w_state_t;
    typedef enum logic {R_IDLE, R_READ}  r_state_t;

    w_state_t      w_state, w_state_nx;
    r_state_t      r_state, r_state_nx;
    logic [AW-1:0] wc, wc_nx, rc, rc_nx;
    logic          wbank, wbank_nx, rbank, rbank_nx;
    logic [1:0]    full, full_nx;
    logic          we, re;

    logic [QW-1:0] ram_lo [2*N2];
    logic [QW-1:0] ram_hi [2*N2];

    logic [DB-1:0] v_pipe, s_pipe;
    logic [QW-1:0] d0_pipe [DB];
    logic [QW-1:0] d1_pipe [DB];

    function automatic logic [AW-1:0] rev(input logic [AW-1:0] x);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = x[AW-1-i];
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            wc      <= '0;
            rc      <= '0;
            wbank   <= 1'b0;
            rbank   <= 1'b0;
            full    <= '0;
        end else begin
            w_state <= w_state_nx;
            r_state <= r_state_nx;
            wc      <= wc_nx;
            rc      <= rc_nx;
            wbank   <= wbank_nx;
            rbank   <= rbank_nx;
            full    <= full_nx;
        end
    end

    always_comb begin
        w_state_nx = w_state;
        wc_nx      = wc;
        wbank_nx   = wbank;
        full_nx    = full;
        we         = 1'b0;
        r_state_nx = r_state;
        rc_nx      = rc;
        rbank_nx   = rbank;
        re         = 1'b0;

        // Pair 0 arrives with in_start, so the IDLE cycle already writes it.
        case (w_state)
            W_IDLE: begin
                if (bus.in_start) begin
                    we         = 1'b1;
                    wc_nx      = AW'(1);
                    w_state_nx = W_WRITE;
                end
            end
            W_WRITE: begin
                we = 1'b1;
                if (wc == LAST) begin
                    full_nx[wbank] = 1'b1;
                    wbank_nx       = ~wbank;
                    wc_nx          = '0;
                    w_state_nx     = bus.in_start ? W_WRITE : W_IDLE;
                end else begin
                    wc_nx = wc + 1'b1;
                end
            end
            default: w_state_nx = W_IDLE;
        endcase

        // Address 0 is issued in the same cycle the full flag is seen.
        case (r_state)
            R_IDLE: begin
                if (full[rbank]) begin
                    re         = 1'b1;
                    rc_nx      = AW'(1);
                    r_state_nx = R_READ;
                end
            end
            R_READ: begin
                re = 1'b1;
                if (rc == LAST) begin
                    full_nx[rbank] = 1'b0;
                    rbank_nx       = ~rbank;
                    rc_nx          = '0;
                    r_state_nx     = full[~rbank] ? R_READ : R_IDLE;
                end else begin
                    rc_nx = rc + 1'b1;
                end
            end
            default: r_state_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) begin
            ram_lo[{wbank, rev(wc)}] <= bus.in_0;
            ram_hi[{wbank, rev(wc)}] <= bus.in_1;
        end
    end

    // Stage 0 is the RAM read register; later stages pad out the BRAM latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_pipe <= '0;
            s_pipe <= '0;
            for (int i = 0; i < DB; i++) begin
                d0_pipe[i] <= '0;
                d1_pipe[i] <= '0;
            end
        end else begin
            v_pipe[0]  <= re;
            s_pipe[0]  <= re && (rc == '0);
            d0_pipe[0] <= re ? ram_lo[{rbank, rc}] : '0;
            d1_pipe[0] <= re ? ram_hi[{rbank, rc}] : '0;
            for (int i = 1; i < DB; i++) begin
                v_pipe[i]  <= v_pipe[i-1];
                s_pipe[i]  <= s_pipe[i-1];
                d0_pipe[i] <= d0_pipe[i-1];
                d1_pipe[i] <= d1_pipe[i-1];
            end
        end
    end

    assign bus.out_valid = v_pipe[DB-1];
    assign bus.out_start = s_pipe[DB-1];
    assign bus.out_0     = d0_pipe[DB-1];
    assign bus.out_1     = d1_pipe[DB-1];

`ifdef NTT_REORDER_ERR_EN
    logic viol, err_q;

    assign viol = (w_state == W_WRITE) && (wc != LAST) && bus.in_start;

    always_ff @(posedge clk) begin
        if (rst)       err_q <= 1'b0;
        else if (viol) err_q <= 1'b1;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_ntt_mdc_reorder.sv
// Randomized bench for ntt_mdc_reorder: drives bit-reversed frames and compares against
// a queue of natural-order pairs stamped with the cycle each one is due.
module tb_ntt_mdc_reorder;
    localparam int LOGQ = 16;
    localparam int LOGN = 3;
    localparam int DB   = 2;
    localparam int N2   = 1 << (LOGN - 1);
    localparam int LAT  = N2 + DB;
`ifdef NTT_REORDER_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic [15:0] d0;
        logic [15:0] d1;
        logic        first;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic mon_en = 1'b0;
    logic [15:0] a [2*N2];
    exp_t exp_q [$];
    exp_t mon_e;

    ntt_mdc_reorder_if #(.LOGQ(LOGQ)) bus ();

    ntt_mdc_reorder #(
        .LOGQ(LOGQ),
        .LOGN(LOGN),
        .DELAY_BRAM(DB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rev_idx(input int k);
        int r = 0;
        for (int b = 0; b < LOGN - 1; b++)
            if (((k >> b) & 1) == 1) r = r | (1 << (LOGN - 2 - b));
        return r;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'(bus.out_valid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_cycle", cyc, mon_e.cyc);
                    chk("out_0", 32'(bus.out_0), 32'(mon_e.d0));
                    chk("out_1", 32'(bus.out_1), 32'(mon_e.d1));
                    chk("out_start", 32'(bus.out_start), 32'(mon_e.first));
                end
            end else begin
                chk("idle_out_0", 32'(bus.out_0), 32'd0);
                chk("idle_out_1", 32'(bus.out_1), 32'd0);
                chk("idle_out_start", 32'(bus.out_start), 32'd0);
                if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                    chk("missing_valid", 32'(bus.out_valid), 32'd1);
                    void'(exp_q.pop_front());
                end
            end
            if (rst) exp_q.delete();
        end
    end

    task automatic push_frame(input int t0);
        exp_t e;
        for (int j = 0; j < N2; j++) begin
            e.cyc   = t0 + LAT + j;
            e.d0    = a[j];
            e.d1    = a[j + N2];
            e.first = (j == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_frame(input int viol_k, input int rst_k);
        int r;
        for (int k = 0; k < N2; k++) begin
            @(posedge clk); #1;
            if (k == 0) push_frame(cyc);
            r = rev_idx(k);
            bus.in_start = (k == 0) || (k == viol_k);
            bus.in_0     = a[r];
            bus.in_1     = a[r + N2];
            if (k == rst_k) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst          = 1'b0;
                bus.in_start = 1'b0;
                return;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.in_start = 1'b0;
            bus.in_0     = 16'($urandom);
            bus.in_1     = 16'($urandom);
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            idle(1);
            guard++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        idle(2);
    endtask

    task automatic fill_a(input int base);
        for (int i = 0; i < 2 * N2; i++) a[i] = 16'(i + base);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 2 * N2; i++) a[i] = 16'($urandom);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_out_start"}, 32'(bus.out_start), 32'd0);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_out_0"}, 32'(bus.out_0), 32'd0);
        chk({tag, "_out_1"}, 32'(bus.out_1), 32'd0);
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
    endtask

    initial begin
        bus.in_start = 1'b0;
        bus.in_0     = '0;
        bus.in_1     = '0;
        rst          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst_init");
        rst    = 1'b0;
        mon_en = 1'b1;
        idle(2);

        fill_a(10);
        drive_frame(-1, -1);
        drain();

        fill_a(10);
        drive_frame(-1, -1);
        fill_a(100);
        drive_frame(-1, -1);
        drain();

        fill_a(10);
        drive_frame(-1, -1);
        idle(11 - N2);
        fill_a(50);
        drive_frame(-1, -1);
        drain();

        fill_rand();
        drive_frame(-1, 2);
        for (int i = 0; i < 12; i++) begin
            chk("rst_no_out", 32'(bus.out_valid), 32'd0);
            idle(1);
        end
        fill_a(10);
        drive_frame(-1, -1);
        drain();

        chk("err_pre", 32'(bus.err), 32'd0);
        fill_a(10);
        drive_frame(1, -1);
        drain();
        chk("err_viol", 32'(bus.err), 32'(ERR_EXP));

        for (int f = 0; f < 10; f++) begin
            fill_rand();
            drive_frame(-1, -1);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 6));
        end
        drain();
        chk("err_sticky", 32'(bus.err), 32'(ERR_EXP));

        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst_final");
        rst = 1'b0;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
